// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller and its helpers.
package ram_ctrl_pkg;

  localparam int unsigned BE_W = 8;
  localparam logic [BE_W-1:0] BE_FULL = '1;
  localparam logic [BE_W-1:0] BE_NONE = '0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapt,
    StWrite,
    StResp
  } state_e;

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge: enabled lanes take new data, others keep the old word.
module byte_merge #(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = '0;
    for (int i = 0; i < int'(DATA_W / 8); i++) begin
      merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Valid/ready front end for a synchronous-read RAM: loads, full stores and
// read-modify-write partial stores, one transaction at a time.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  import ram_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] merged;

  byte_merge #(
    .DATA_W(DATA_W)
  ) u_byte_merge (
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (mem_out),
    .merged(merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          write_d = req_write;
          // Stores report zero data, so clear any previous load result.
          rdata_d = '0;
          if (!req_write) begin
            state_d = StIssue;
          end else if (&req_be) begin
            state_d = StWrite;
          end else if (~|req_be) begin
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StCapt;
      StCapt: begin
        if (write_q) begin
          wdata_d = merged;
          state_d = StWrite;
        end else begin
          rdata_d = mem_out;
          state_d = StResp;
        end
      end
      StWrite: state_d = StResp;
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Gated by reset so no request looks acceptable while the block is held in reset.
  assign req_ready   = (state_q == StIdle) && reset_n;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_rdata   = rdata_q;
  assign busy        = (state_q != StIdle);
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_write   = (state_q == StWrite);

endmodule
